// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster counters with a registered, pixel-aligned VGA output stage.
// Define VGA_TIMING_TEST_PATTERN_EN to add a test_pattern input that selects 64-px colour bars.
module vga_timing_gen #(
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic        CLOCK_25,
  input  logic        reset,
  input  logic [2:0]  color_in,
`ifdef VGA_TIMING_TEST_PATTERN_EN
  input  logic        test_pattern,
`endif
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        active,
  output logic        frame_start,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [2:0]  vga_rgb,
  output logic        vga_blank_n
);

  localparam logic [11:0] HV  = 12'(H_VISIBLE);
  localparam logic [11:0] VV  = 12'(V_VISIBLE);
  localparam logic [11:0] HT  = 12'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [11:0] VT  = 12'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [11:0] HSB = 12'(H_VISIBLE + H_FRONT);
  localparam logic [11:0] HSE = 12'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [11:0] VSB = 12'(V_VISIBLE + V_FRONT);
  localparam logic [11:0] VSE = 12'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic        POL = (SYNC_ACTIVE_LOW != 0);

  logic [11:0] r_h;
  logic [11:0] r_v;
  logic        r_fs;
  logic        r_hs;
  logic        r_vs;
  logic [2:0]  r_rgb;
  logic        r_bn;

  logic        w_active;
  logic        w_hs_raw;
  logic        w_vs_raw;
  logic [2:0]  w_pix;

  // Raster position: h wraps every line, v advances on each h wrap
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == HT - 12'd1) begin
      r_h <= '0;
      r_v <= (r_v == VT - 12'd1) ? 12'd0 : r_v + 12'd1;
    end else begin
      r_h <= r_h + 12'd1;
    end
  end

  // Decode visibility, 1-based coordinates and raw sync windows
  always_comb begin
    w_active = (r_h < HV) && (r_v < VV);
    w_hs_raw = (r_h >= HSB) && (r_h <= HSE);
    w_vs_raw = (r_v >= VSB) && (r_v <= VSE);
    x        = w_active ? r_h + 12'd1 : 12'd0;
    y        = w_active ? r_v + 12'd1 : 12'd0;
  end

  // Pick the pixel source: external colour or built-in bars
  always_comb begin
    w_pix = color_in;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    if (test_pattern) w_pix = r_h[8:6];
`endif
  end

  // One-cycle output stage keeping colour, blanking and syncs aligned
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      r_rgb <= '0;
      r_bn  <= 1'b0;
      r_hs  <= POL;
      r_vs  <= POL;
      r_fs  <= 1'b0;
    end else begin
      r_rgb <= w_active ? w_pix : 3'd0;
      r_bn  <= w_active;
      r_hs  <= w_hs_raw ^ POL;
      r_vs  <= w_vs_raw ^ POL;
      r_fs  <= (r_h == 12'd0) && (r_v == VV);
    end
  end

  assign active      = w_active;
  assign frame_start = r_fs;
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_rgb     = r_rgb;
  assign vga_blank_n = r_bn;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: two instances (default 640x480 timing and a shrunk raster)
// checked every cycle against a linear-position reference model.
module tb_vga_timing_gen;

  localparam int NI  = 2;
  localparam int SHV = 40, SHF = 4, SHS = 8, SHB = 6;
  localparam int SVV = 30, SVF = 3, SVS = 2, SVB = 5;
  localparam int SHT = SHV + SHF + SHS + SHB;
  localparam int SVT = SVV + SVF + SVS + SVB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] col = '0;

  logic [NI-1:0][11:0] dx, dy;
  logic [NI-1:0][2:0]  drgb;
  logic [NI-1:0]       dact, dfs, dhs, dvs, dbn;

  int cf [NI][9];
  int pos [NI];
  logic [2:0] e_rgb [NI];
  logic e_bn [NI];
  logic e_fs [NI];
  logic e_hs [NI];
  logic e_vs [NI];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int hs_run = 0, bn_run = 0, fs_last = -1, n_fs = 0;

  always #20 clk = ~clk;

  vga_timing_gen u_d (
    .CLOCK_25(clk), .reset(rst), .color_in(col),
`ifdef VGA_TIMING_TEST_PATTERN_EN
    .test_pattern(1'b0),
`endif
    .x(dx[0]), .y(dy[0]), .active(dact[0]), .frame_start(dfs[0]),
    .vga_hs(dhs[0]), .vga_vs(dvs[0]), .vga_rgb(drgb[0]), .vga_blank_n(dbn[0])
  );

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
    .SYNC_ACTIVE_LOW(0)
  ) u_s (
    .CLOCK_25(clk), .reset(rst), .color_in(col),
`ifdef VGA_TIMING_TEST_PATTERN_EN
    .test_pattern(1'b0),
`endif
    .x(dx[1]), .y(dy[1]), .active(dact[1]), .frame_start(dfs[1]),
    .vga_hs(dhs[1]), .vga_vs(dvs[1]), .vga_rgb(drgb[1]), .vga_blank_n(dbn[1])
  );

  function automatic int ht(int i);
    return cf[i][0] + cf[i][1] + cf[i][2] + cf[i][3];
  endfunction

  function automatic int vt(int i);
    return cf[i][4] + cf[i][5] + cf[i][6] + cf[i][7];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  // Reference: one linear position per frame; registered outputs from the pre-edge position
  always @(posedge clk) begin : mdl
    int h, v;
    bit a, hr, vr;
    for (int i = 0; i < NI; i++) begin
      h  = pos[i] % ht(i);
      v  = pos[i] / ht(i);
      a  = (h < cf[i][0]) && (v < cf[i][4]);
      hr = (h >= cf[i][0] + cf[i][1]) && (h < cf[i][0] + cf[i][1] + cf[i][2]);
      vr = (v >= cf[i][4] + cf[i][5]) && (v < cf[i][4] + cf[i][5] + cf[i][6]);
      if (rst) begin
        e_rgb[i] = '0;
        e_bn[i]  = 1'b0;
        e_fs[i]  = 1'b0;
        e_hs[i]  = (cf[i][8] != 0);
        e_vs[i]  = (cf[i][8] != 0);
        pos[i]   = 0;
      end else begin
        e_rgb[i] = a ? col : 3'd0;
        e_bn[i]  = a;
        e_fs[i]  = (pos[i] == cf[i][4] * ht(i));
        e_hs[i]  = (cf[i][8] != 0) ? !hr : hr;
        e_vs[i]  = (cf[i][8] != 0) ? !vr : vr;
        pos[i]   = (pos[i] + 1) % (ht(i) * vt(i));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) begin
      int h, v;
      bit a;
      h = pos[i] % ht(i);
      v = pos[i] / ht(i);
      a = (h < cf[i][0]) && (v < cf[i][4]);
      chk(i == 0 ? "d.x" : "s.x", dx[i], a ? h + 1 : 0);
      chk(i == 0 ? "d.y" : "s.y", dy[i], a ? v + 1 : 0);
      chk(i == 0 ? "d.active" : "s.active", dact[i], a);
      chk(i == 0 ? "d.rgb" : "s.rgb", drgb[i], e_rgb[i]);
      chk(i == 0 ? "d.blank_n" : "s.blank_n", dbn[i], e_bn[i]);
      chk(i == 0 ? "d.hs" : "s.hs", dhs[i], e_hs[i]);
      chk(i == 0 ? "d.vs" : "s.vs", dvs[i], e_vs[i]);
      chk(i == 0 ? "d.frame_start" : "s.frame_start", dfs[i], e_fs[i]);
    end
    if (rst) begin
      hs_run  = 0;
      bn_run  = 0;
      fs_last = -1;
    end else begin
      if (!dhs[0]) hs_run++;
      else begin
        if (hs_run != 0) chk("hs_width", hs_run, 96);
        hs_run = 0;
      end
      if (dbn[0]) bn_run++;
      else begin
        if (bn_run != 0) chk("blank_run", bn_run, 640);
        bn_run = 0;
      end
      if (dfs[1]) begin
        if (fs_last >= 0) chk("fs_gap", cyc - fs_last, SHT * SVT);
        fs_last = cyc;
        n_fs++;
      end
    end
  endtask

  initial begin
    int n5, k;
    bit got;
    cf[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
    cf[1] = '{SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 0};
    rst = 1'b1;
    col = 3'd0;
    repeat (5) begin
      col = 3'($urandom);
      step();
    end
    rst = 1'b0;

    repeat (6000) begin
      col = 3'($urandom);
      step();
    end

    rst = 1'b1;
    step();
    rst = 1'b0;
    n5 = 0;
    repeat (900) begin
      col = (dx[0] == 12'd1 && dy[0] == 12'd1) ? 3'b101 : 3'b000;
      step();
      if (drgb[0] == 3'b101) begin
        n5++;
        chk("align_bn", dbn[0], 1);
      end
    end
    chk("align_cnt", n5, 1);

    col = 3'b111;
    repeat (3000) begin
      step();
      if (!dbn[0]) chk("blank_rgb", drgb[0], 0);
    end

    repeat ($urandom_range(500, 3000)) begin
      col = 3'($urandom);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    k = 0;
    got = 0;
    while (!got && k < 5000) begin
      col = 3'($urandom);
      step();
      k++;
      if (dfs[1]) got = 1;
    end
    chk("fs_latency", k, SHT * SVV + 1);

    repeat (40000) begin
      col = 3'($urandom);
      step();
    end
    chk("fs_seen", (n_fs >= 10) ? 1 : 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
